// File: rtl/demux8_deframer_pkg.sv
// rtl/demux8_deframer_pkg.sv - shared constants for the 8-slot serial deframer
package demux8_deframer_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  localparam int LANES = 8;
  localparam int SEL_W = 3;

endpackage

// File: rtl/demux8_deframer_demux1x8.sv
// rtl/demux8_deframer_demux1x8.sv - gate-level 1:8 demux, inverse of the 8:1 mux minterm decode

module not_gate (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module and_gate #(
  parameter int N = 2
) (
  input  logic [N-1:0] a,
  output logic         y
);
  assign y = &a;
endmodule

module demux1x8
  import demux8_deframer_pkg::*;
(
  input  logic             d,
  input  logic             en,
  input  logic [SEL_W-1:0] s,
  output logic [LANES-1:0] y
);

  logic [SEL_W-1:0] sn;

  // inverted select literals, shared by all eight minterms
  for (genvar i = 0; i < SEL_W; i++) begin : g_inv
    not_gate u_not (.a(s[i]), .y(sn[i]));
  end

  // output k is d & en & (s == k), one AND per minterm
  for (genvar k = 0; k < LANES; k++) begin : g_term
    logic [SEL_W-1:0] lit;
    for (genvar i = 0; i < SEL_W; i++) begin : g_lit
      assign lit[i] = (((k >> i) & 1) != 0) ? s[i] : sn[i];
    end
    and_gate #(.N(SEL_W + 2)) u_and (.a({d, en, lit}), .y(y[k]));
  end

endmodule

// File: rtl/demux8_deframer.sv
// rtl/demux8_deframer.sv - serial-to-parallel 8-slot deframer with gap timeout and resync detection
module demux8_deframer
  import demux8_deframer_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [LANES-1:0] dout,
  output logic             dout_valid,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             frame_err
);

  // gap counter value on the cycle whose idle edge completes the timeout
  localparam logic [7:0] GAP_LAST = 8'(TIMEOUT - 1);

  logic             state, state_nxt;
  logic [LANES-2:0] lane;
  logic [7:0]       gap_cnt;
  logic             accept, resync, gap_hit, complete;
  logic [SEL_W-1:0] wsel;
  logic [LANES-1:0] lane_en;
  logic             dout_valid_nxt, frame_err_nxt;

  // a frame_start always writes slot 0; otherwise the running slot index is used
  assign accept = din_valid && (state == ST_SHIFT || frame_start);
  assign wsel   = frame_start ? '0 : sel;
  assign resync = din_valid && frame_start && (state == ST_SHIFT);
  assign gap_hit = (state == ST_SHIFT) && !din_valid && (gap_cnt == GAP_LAST);

  demux1x8 u_dec (
    .d  (1'b1),
    .en (accept),
    .s  (wsel),
    .y  (lane_en)
  );

  // slot 7 is never stored in a lane: its enable marks word completion
  assign complete = lane_en[LANES-1];
  assign busy     = state;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next state: enter SHIFT on a marked bit, leave on completion or gap timeout
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT: if (complete || gap_hit) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // next values of the registered pulse outputs
  always_comb begin
    dout_valid_nxt = complete;
    frame_err_nxt  = resync || gap_hit;
  end

  // lanes, output word, slot index and gap counter
  always_ff @(posedge clk) begin
    if (rst) begin
      lane       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      sel        <= '0;
      gap_cnt    <= '0;
    end else begin
      dout_valid <= dout_valid_nxt;
      frame_err  <= frame_err_nxt;
      for (int k = 0; k < LANES - 1; k++) begin
        if (lane_en[k]) lane[k] <= din;
      end
      if (complete) begin
        dout <= {din, lane};
        sel  <= '0;
      end else if (accept) begin
        sel <= wsel + SEL_W'(1);
      end else if (gap_hit) begin
        sel <= '0;
      end
      if (state == ST_SHIFT && !din_valid) gap_cnt <= gap_hit ? 8'd0 : gap_cnt + 8'd1;
      else                                 gap_cnt <= 8'd0;
    end
  end

endmodule

// File: tb/tb_demux8_deframer.sv
// tb/tb_demux8_deframer.sv - directed bench for demux8_deframer
module tb_demux8_deframer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] sel;
  logic       busy;
  logic       frame_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  demux8_deframer #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_start(frame_start),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sel        (sel),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  // inputs change at a falling edge; on return the next falling edge has passed,
  // so outputs reflect the rising edge that sampled these inputs
  task automatic step(input logic v, input logic fs, input logic d);
    din_valid   = v;
    frame_start = fs;
    din         = d;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout got=%h exp=00", dout); end
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
    vectors++; if (sel !== 3'd0) begin miscompares++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    rst = 1'b0;
  endtask

  task automatic test_continuous();
    logic [7:0] w;
    w = 8'b0100_1101;  // slot0..7 = 1,0,1,1,0,0,1,0
    for (int i = 0; i < 8; i++) begin
      step(1, i == 0, w[i]);
      if (i < 7) begin
        vectors++; if (sel !== 3'(i + 1)) begin miscompares++; $display("FAIL cont_sel slot=%0d got=%0d exp=%0d", i, sel, i + 1); end
        vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL cont_early_valid slot=%0d got=%b exp=0", i, dout_valid); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL cont_busy slot=%0d got=%b exp=1", i, busy); end
      end
    end
    vectors++; if (dout !== 8'h4D) begin miscompares++; $display("FAIL cont_dout got=%h exp=4d", dout); end
    vectors++; if (dout_valid !== 1'b1) begin miscompares++; $display("FAIL cont_valid got=%b exp=1", dout_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cont_busy_after got=%b exp=0", busy); end
    vectors++; if (sel !== 3'd0) begin miscompares++; $display("FAIL cont_sel_wrap got=%0d exp=0", sel); end
    step(0, 0, 0);
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL cont_valid_pulse got=%b exp=0", dout_valid); end
    vectors++; if (dout !== 8'h4D) begin miscompares++; $display("FAIL cont_dout_hold got=%h exp=4d", dout); end
  endtask

  task automatic test_gapped();
    logic [7:0] w;
    w = 8'hA5;
    for (int i = 0; i < 4; i++) step(1, i == 0, w[i]);
    for (int g = 0; g < 3; g++) begin
      step(0, 0, 0);
      vectors++; if (sel !== 3'd4) begin miscompares++; $display("FAIL gap_sel idle=%0d got=%0d exp=4", g, sel); end
      vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL gap_err idle=%0d got=%b exp=0", g, frame_err); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL gap_busy idle=%0d got=%b exp=1", g, busy); end
    end
    for (int i = 4; i < 8; i++) begin
      step(1, 0, w[i]);
      vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL gap_err2 slot=%0d got=%b exp=0", i, frame_err); end
    end
    vectors++; if (dout !== 8'hA5) begin miscompares++; $display("FAIL gap_dout got=%h exp=a5", dout); end
    vectors++; if (dout_valid !== 1'b1) begin miscompares++; $display("FAIL gap_valid got=%b exp=1", dout_valid); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 5; i++) step(1, i == 0, 1'b1);
    for (int g = 1; g <= 16; g++) begin
      step(0, 0, 0);
      if (g < 16) begin
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL to_early_err idle=%0d got=%b exp=0", g, frame_err); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL to_busy idle=%0d got=%b exp=1", g, busy); end
      end
      vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL to_valid idle=%0d got=%b exp=0", g, dout_valid); end
    end
    vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("FAIL to_err got=%b exp=1", frame_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL to_busy_end got=%b exp=0", busy); end
    vectors++; if (sel !== 3'd0) begin miscompares++; $display("FAIL to_sel got=%0d exp=0", sel); end
    vectors++; if (dout !== 8'hA5) begin miscompares++; $display("FAIL to_dout got=%h exp=a5", dout); end
    step(0, 0, 0);
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL to_err_pulse got=%b exp=0", frame_err); end
  endtask

  task automatic test_resync();
    logic [7:0] w;
    int pulses;
    w = 8'h3C;
    pulses = 0;
    for (int i = 0; i < 5; i++) step(1, i == 0, 1'b1);
    vectors++; if (sel !== 3'd5) begin miscompares++; $display("FAIL rs_pre_sel got=%0d exp=5", sel); end
    for (int i = 0; i < 8; i++) begin
      step(1, i == 0, w[i]);
      if (dout_valid === 1'b1) pulses++;
      if (i == 0) begin
        vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("FAIL rs_err got=%b exp=1", frame_err); end
        vectors++; if (sel !== 3'd1) begin miscompares++; $display("FAIL rs_sel got=%0d exp=1", sel); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rs_busy got=%b exp=1", busy); end
        vectors++; if (dout !== 8'hA5) begin miscompares++; $display("FAIL rs_dout_hold got=%h exp=a5", dout); end
      end else begin
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL rs_err_extra slot=%0d got=%b exp=0", i, frame_err); end
      end
    end
    vectors++; if (dout !== 8'h3C) begin miscompares++; $display("FAIL rs_dout got=%h exp=3c", dout); end
    step(0, 0, 0);
    if (dout_valid === 1'b1) pulses++;
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL rs_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    int t[2];
    logic [7:0] v[2];
    int n;
    w = 16'h01FF;  // first frame FF, then 01
    n = 0;
    t[0] = 0; t[1] = 0; v[0] = 8'h00; v[1] = 8'h00;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) step(1, (i % 8) == 0, w[i]);
      else        step(0, 0, 0);
      if (dout_valid === 1'b1) begin
        if (n < 2) begin t[n] = i; v[n] = dout; end
        n++;
      end
    end
    vectors++; if (n !== 2) begin miscompares++; $display("FAIL b2b_pulses got=%0d exp=2", n); end
    vectors++; if (t[1] - t[0] !== 8) begin miscompares++; $display("FAIL b2b_spacing got=%0d exp=8", t[1] - t[0]); end
    vectors++; if (v[0] !== 8'hFF) begin miscompares++; $display("FAIL b2b_first got=%h exp=ff", v[0]); end
    vectors++; if (v[1] !== 8'h01) begin miscompares++; $display("FAIL b2b_second got=%h exp=01", v[1]); end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 3; i++) step(1, i == 0, 1'b1);
    vectors++; if (sel !== 3'd3) begin miscompares++; $display("FAIL mr_pre_sel got=%0d exp=3", sel); end
    rst = 1'b1;
    step(1, 0, 1'b1);
    rst = 1'b0;
    vectors++; if (sel !== 3'd0) begin miscompares++; $display("FAIL mr_sel got=%0d exp=0", sel); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mr_busy got=%b exp=0", busy); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL mr_err got=%b exp=0", frame_err); end
    vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL mr_dout got=%h exp=00", dout); end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, i[0]);
      vectors++; if (sel !== 3'd0) begin miscompares++; $display("FAIL stray_sel n=%0d got=%0d exp=0", i, sel); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stray_busy n=%0d got=%b exp=0", i, busy); end
      vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL stray_valid n=%0d got=%b exp=0", i, dout_valid); end
      vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL stray_err n=%0d got=%b exp=0", i, frame_err); end
    end
    vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL stray_dout got=%h exp=00", dout); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_continuous();
    test_gapped();
    test_timeout();
    test_resync();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
